// File: rtl/dsdmnist_result_reader_pkg.sv
// Shared definitions for the MNIST result reader: default sizing and FSM state encoding.
package dsdmnist_result_reader_pkg;

    localparam int DEF_IMGNUM = 10;
    localparam int DEF_ADDRW  = 4;
    localparam int DEF_DATAW  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        CLEAR   = 2'd3
    } state_t;

endpackage

// File: rtl/dsdmnist_result_ram.sv
// Result data array: one write port, one read port with a registered read.
// The array itself is never reset; only the read register returns to zero.
module dsdmnist_result_ram
    import dsdmnist_result_reader_pkg::*;
#(
    parameter int DEPTH = DEF_IMGNUM,
    parameter int ADDRW = DEF_ADDRW,
    parameter int DATAW = DEF_DATAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [DATAW-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [DATAW-1:0] rd_data
);

    logic [DATAW-1:0] mem [DEPTH];

    // Store a classified digit; addresses outside the array never match.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDRW'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Registered read, held between read strobes so the presented word stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr == ADDRW'(i)) begin
                    rd_data <= mem[i];
                end
            end
        end
    end

endmodule

// File: rtl/dsdmnist_result_reader.sv
// Collects per-image results from the accelerator, then streams them out with a
// valid/ready handshake once the accelerator signals completion.
module dsdmnist_result_reader
    import dsdmnist_result_reader_pkg::*;
#(
    parameter int IMGNUM = DEF_IMGNUM,
    parameter int ADDRW  = DEF_ADDRW,
    parameter int DATAW  = DEF_DATAW
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_RESULTBUF_EN,
    input  logic             i_RESULTBUF_WE,
    input  logic [ADDRW-1:0] i_RESULTBUF_ADDR,
    input  logic [DATAW-1:0] i_RESULTBUF_DATA,
    input  logic             i_ARMINT,
    output logic             o_RD_VALID,
    input  logic             i_RD_READY,
    output logic [DATAW-1:0] o_RD_DATA,
    output logic [ADDRW-1:0] o_RD_IDX,
    output logic             o_RD_LAST,
    output logic             o_RD_MISSING,
    output logic             o_BUSY,
    output logic             o_OVERRUN
);

    // One extra bit so IMGNUM == 2**ADDRW still compares correctly.
    localparam logic [ADDRW:0]   IMG_LIMIT = (ADDRW+1)'(IMGNUM);
    localparam logic [ADDRW-1:0] LAST_IDX  = ADDRW'(IMGNUM - 1);

    state_t              state;
    state_t              next_state;
    logic [ADDRW-1:0]    idx;
    logic [IMGNUM-1:0]   written;
    logic                overrun;
    logic                wr_req;
    logic                wr_ok;
    logic                handshake;
    logic                is_last;
    logic                missing_now;

    assign wr_req    = i_RESULTBUF_EN & i_RESULTBUF_WE;
    assign wr_ok     = wr_req && (state == IDLE) && ({1'b0, i_RESULTBUF_ADDR} < IMG_LIMIT);
    assign handshake = (state == PRESENT) && i_RD_READY;
    assign is_last   = (idx == LAST_IDX);

    dsdmnist_result_ram #(
        .DEPTH (IMGNUM),
        .ADDRW (ADDRW),
        .DATAW (DATAW)
    ) u_ram (
        .clk     (i_CLK),
        .rst     (i_RST),
        .wr_en   (wr_ok),
        .wr_addr (i_RESULTBUF_ADDR),
        .wr_data (i_RESULTBUF_DATA),
        .rd_en   (state == FETCH),
        .rd_addr (idx),
        .rd_data (o_RD_DATA)
    );

    // Sequence IDLE -> FETCH -> PRESENT (-> FETCH ...) -> CLEAR -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_ARMINT) next_state = FETCH;
            FETCH:   next_state = PRESENT;
            PRESENT: if (handshake) next_state = is_last ? CLEAR : FETCH;
            CLEAR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) state <= IDLE;
        else       state <= next_state;
    end

    // Readout index: restarts at 0 on arm, advances on each accepted non-final word.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            idx <= '0;
        end else if ((state == IDLE) && i_ARMINT) begin
            idx <= '0;
        end else if (handshake && !is_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Written flags: set by accepted writes, wiped in one shot after each run.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            written <= '0;
        end else if (state == CLEAR) begin
            written <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < IMGNUM; i++) begin
                if (i_RESULTBUF_ADDR == ADDRW'(i)) written[i] <= 1'b1;
            end
        end
    end

    // Sticky flag for writes the accelerator attempted during a readout.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)                      overrun <= 1'b0;
        else if (wr_req && state != IDLE) overrun <= 1'b1;
    end

    // Flag lookup for the presented index; flags cannot change while presenting.
    always_comb begin
        missing_now = 1'b0;
        for (int i = 0; i < IMGNUM; i++) begin
            if (idx == ADDRW'(i)) missing_now = ~written[i];
        end
    end

    assign o_RD_VALID   = (state == PRESENT);
    assign o_RD_IDX     = idx;
    assign o_RD_LAST    = (state == PRESENT) && is_last;
    assign o_RD_MISSING = (state == PRESENT) && missing_now;
    assign o_BUSY       = (state != IDLE);
    assign o_OVERRUN    = overrun;

endmodule

// File: tb/tb_dsdmnist_result_reader.sv
// Directed scoreboard bench for the MNIST result reader.
module tb_dsdmnist_result_reader;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
        logic       missing;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       buf_en, buf_we, armint, rd_ready;
    logic [3:0] buf_addr;
    logic [7:0] buf_data;
    logic       rd_valid, rd_last, rd_missing, busy, overrun;
    logic [7:0] rd_data;
    logic [3:0] rd_idx;

    int         assert_count = 0;
    int         fail_count   = 0;
    logic [7:0] mem_model [10];
    bit         flag_model [10];
    exp_t       sb [$];

    dsdmnist_result_reader dut (
        .i_CLK            (clk),
        .i_RST            (rst),
        .i_RESULTBUF_EN   (buf_en),
        .i_RESULTBUF_WE   (buf_we),
        .i_RESULTBUF_ADDR (buf_addr),
        .i_RESULTBUF_DATA (buf_data),
        .i_ARMINT         (armint),
        .o_RD_VALID       (rd_valid),
        .i_RD_READY       (rd_ready),
        .o_RD_DATA        (rd_data),
        .o_RD_IDX         (rd_idx),
        .o_RD_LAST        (rd_last),
        .o_RD_MISSING     (rd_missing),
        .o_BUSY           (busy),
        .o_OVERRUN        (overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        assert_count++;
        assert (obs === exp_v) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic write_entry(input int addr, input logic [7:0] data);
        @(negedge clk);
        buf_en = 1'b1; buf_we = 1'b1;
        buf_addr = 4'(addr); buf_data = data;
        if (addr < 10) begin
            mem_model[addr]  = data;
            flag_model[addr] = 1'b1;
        end
        @(negedge clk);
        buf_en = 1'b0; buf_we = 1'b0;
    endtask

    task automatic write_digits(input int count, input int base);
        logic [7:0] digits [10];
        digits = '{8'd7, 8'd2, 8'd1, 8'd0, 8'd4, 8'd1, 8'd4, 8'd9, 8'd5, 8'd9};
        for (int i = 0; i < count; i++) write_entry(i, digits[i] + 8'(base));
    endtask

    // One readout: ready_mode 0 = always ready, 1 = ready one cycle in three.
    task automatic run_readout(input int ready_mode, input int mid_arm_at, input int busy_write_at,
                               input int reset_at, input int arm_write_addr, input logic [7:0] arm_write_data);
        exp_t held;
        exp_t got;
        exp_t want;
        bit   hold_valid;
        int   cyc;
        bit   was_reset;
        was_reset = 1'b0;
        @(negedge clk);
        armint = 1'b1;
        if (arm_write_addr >= 0) begin
            buf_en = 1'b1; buf_we = 1'b1;
            buf_addr = 4'(arm_write_addr); buf_data = arm_write_data;
            mem_model[arm_write_addr]  = arm_write_data;
            flag_model[arm_write_addr] = 1'b1;
        end
        for (int i = 0; i < 10; i++)
            sb.push_back('{data: mem_model[i], idx: 4'(i), last: (i == 9), missing: !flag_model[i]});
        @(negedge clk);
        armint = 1'b0; buf_en = 1'b0; buf_we = 1'b0;
        check_output("fetch_valid_low", rd_valid, 0);
        check_output("busy_after_arm", busy, 1);
        @(negedge clk);
        check_output("first_valid_latency", rd_valid, 1);
        hold_valid = 1'b0;
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            rd_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 2);
            armint   = (cyc == mid_arm_at);
            if (cyc == busy_write_at) begin
                buf_en = 1'b1; buf_we = 1'b1; buf_addr = 4'd3; buf_data = 8'hAA;
            end else begin
                buf_en = 1'b0; buf_we = 1'b0;
            end
            if (reset_at >= 0 && rd_valid && rd_idx == 4'(reset_at)) begin
                rst = 1'b1;
                #1;
                check_output("rst_valid", rd_valid, 0);
                check_output("rst_busy", busy, 0);
                check_output("rst_idx", rd_idx, 0);
                check_output("rst_data", rd_data, 0);
                check_output("rst_last", rd_last, 0);
                check_output("rst_missing", rd_missing, 0);
                check_output("rst_overrun", overrun, 0);
                sb.delete();
                for (int i = 0; i < 10; i++) flag_model[i] = 1'b0;
                was_reset = 1'b1;
                break;
            end
            got = '{data: rd_data, idx: rd_idx, last: rd_last, missing: rd_missing};
            if (hold_valid) begin
                check_output("stable_valid", rd_valid, 1);
                check_output("stable_word", got, held);
            end
            if (rd_valid && rd_ready) begin
                want = sb.pop_front();
                check_output($sformatf("word%0d_data", want.idx), rd_data, want.data);
                check_output($sformatf("word%0d_idx", want.idx), rd_idx, want.idx);
                check_output($sformatf("word%0d_last", want.idx), rd_last, want.last);
                check_output($sformatf("word%0d_missing", want.idx), rd_missing, want.missing);
                hold_valid = 1'b0;
            end else if (rd_valid) begin
                hold_valid = 1'b1;
                held = got;
            end else begin
                hold_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        armint = 1'b0; buf_en = 1'b0; buf_we = 1'b0; rd_ready = 1'b0;
        if (was_reset) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end else begin
            check_output("all_words_delivered", sb.size(), 0);
            sb.delete();
            check_output("clear_valid_low", rd_valid, 0);
            @(negedge clk);
            check_output("idle_after_run", busy, 0);
            for (int i = 0; i < 4; i++) begin
                check_output("no_extra_word", rd_valid, 0);
                @(negedge clk);
            end
            for (int i = 0; i < 10; i++) flag_model[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; buf_en = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_data = '0;
        armint = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_model[i] = 8'h00; flag_model[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_output("reset_valid", rd_valid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_overrun", overrun, 0);
        check_output("reset_data", rd_data, 0);
        check_output("reset_idx", rd_idx, 0);
        check_output("reset_last", rd_last, 0);
        check_output("reset_missing", rd_missing, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic readout, ready held high");
        write_digits(10, 0);
        run_readout(0, -1, -1, -1, -1, 8'h00);

        $display("[TB] readout with ready one cycle in three");
        write_digits(10, 0);
        run_readout(1, -1, -1, -1, -1, 8'h00);

        $display("[TB] partial writes then run without writes");
        write_digits(9, 16);
        run_readout(0, -1, -1, -1, -1, 8'h00);
        run_readout(1, -1, -1, -1, -1, 8'h00);

        $display("[TB] write coinciding with arm");
        run_readout(0, -1, -1, -1, 5, 8'h33);

        $display("[TB] out-of-range write in idle");
        write_entry(12, 8'h5A);
        check_output("addr12_no_overrun", overrun, 0);

        $display("[TB] write during readout");
        write_digits(10, 32);
        run_readout(0, -1, 1, -1, -1, 8'h00);
        check_output("overrun_set", overrun, 1);

        $display("[TB] reset mid-readout then fresh run with a stray arm");
        write_digits(10, 48);
        run_readout(1, -1, -1, 5, -1, 8'h00);
        write_digits(10, 64);
        run_readout(0, 4, -1, -1, -1, 8'h00);
        check_output("overrun_after_reset", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
